dma_mch_engine: RTL and testbench

DMA_MCH_ENGINE -- requirements
Module: dma_mch_engine

---
 rtl/dma_mch_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_dma_mch_engine.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mch_engine.sv
// dma_mch_engine: NCH-channel word-copy DMA, ICB config slave + ICB master; `DMA_IRQ_EN adds dma_irq.
// Latency: config response one cycle after accept; master ~5 cycles per word plus slave wait states.
// Backpressure: config accepts while its single response slot is free; master holds cmd until ready.
module dma_mch_engine #(
    parameter int          NCH       = 2,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_cfg_icb_cmd_valid,
    input  logic        dma_cfg_icb_cmd_read,
    input  logic [31:0] dma_cfg_icb_cmd_addr,
    input  logic [31:0] dma_cfg_icb_cmd_wdata,
    input  logic [3:0]  dma_cfg_icb_cmd_wmask,
    output logic        dma_cfg_icb_cmd_ready,
    output logic        dma_cfg_icb_rsp_valid,
    output logic        dma_cfg_icb_rsp_err,
    output logic [31:0] dma_cfg_icb_rsp_rdata,
    input  logic        dma_cfg_icb_rsp_ready,
    output logic        dma_icb_cmd_valid,
    output logic        dma_icb_cmd_read,
    output logic [31:0] dma_icb_cmd_addr,
    output logic [31:0] dma_icb_cmd_wdata,
    output logic [3:0]  dma_icb_cmd_wmask,
    input  logic        dma_icb_cmd_ready,
    input  logic        dma_icb_rsp_valid,
    input  logic        dma_icb_rsp_err,
    input  logic [31:0] dma_icb_rsp_rdata,
    output logic        dma_icb_rsp_ready,
    output logic        dma_irq
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef DMA_IRQ_EN
    localparam logic IRQ_IMPL = 1'b1;
`else
    localparam logic IRQ_IMPL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ARB, RD_CMD, RD_RSP, WR_CMD, WR_RSP, NEXT} state_t;

    logic [31:0]      src_q [NCH];
    logic [31:0]      dst_q [NCH];
    logic [LEN_W-1:0] len_q [NCH];
    logic [NCH-1:0]   busy_q, done_q, err_q, ien_q;
    logic [NCH-1:0]   busy_set, busy_clr, done_set, done_clr, err_set, err_clr;

    state_t           state;
    logic [CW-1:0]    rr_ptr, cur_ch, gnt;
    logic [31:0]      cur_src, cur_dst;
    logic [LEN_W-1:0] cnt_q;
    logic             ready_en;

    logic             cfg_hs, in_map, wr_ok, found, fin_vld, fin_err;
    logic [31:0]      off, rd_val;
    logic [CW-1:0]    cfg_ch;
    logic [1:0]       cfg_reg;
    int               idx;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Ready is held low until the first clock after reset so every output is 0 in reset.
    assign dma_cfg_icb_cmd_ready = ready_en && (!dma_cfg_icb_rsp_valid || dma_cfg_icb_rsp_ready);
    assign cfg_hs  = dma_cfg_icb_cmd_valid && dma_cfg_icb_cmd_ready;
    assign off     = dma_cfg_icb_cmd_addr - BASE_ADDR;
    assign in_map  = (dma_cfg_icb_cmd_addr >= BASE_ADDR) && (off < 32'(16 * NCH))
                     && (dma_cfg_icb_cmd_addr[1:0] == 2'b00);
    assign cfg_ch  = off[4 +: CW];
    assign cfg_reg = off[3:2];
    assign wr_ok   = cfg_hs && !dma_cfg_icb_cmd_read && in_map;

    assign fin_err = ((state == RD_RSP) || (state == WR_RSP)) && dma_icb_rsp_valid && dma_icb_rsp_err;
    assign fin_vld = fin_err || ((state == NEXT) && (cnt_q == LEN_W'(1)));

    always_comb begin
        case (cfg_reg)
            2'd0:    rd_val = src_q[cfg_ch];
            2'd1:    rd_val = dst_q[cfg_ch];
            2'd2:    rd_val = 32'(len_q[cfg_ch]);
            default: rd_val = {27'd0, ien_q[cfg_ch], err_q[cfg_ch], done_q[cfg_ch], busy_q[cfg_ch], 1'b0};
        endcase
    end

    // Hardware completion is OR-ed in after the W1C mask so a coincident set wins.
    always_comb begin
        busy_set = '0; busy_clr = '0; done_set = '0; done_clr = '0; err_set = '0; err_clr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_ok && cfg_reg == 2'd3 && dma_cfg_icb_cmd_wmask[0] && cfg_ch == CW'(c)) begin
                if (dma_cfg_icb_cmd_wdata[0] && !busy_q[c]) begin
                    if (len_q[c] == '0) done_set[c] = 1'b1;
                    else                busy_set[c] = 1'b1;
                end
                done_clr[c] = dma_cfg_icb_cmd_wdata[2];
                err_clr[c]  = dma_cfg_icb_cmd_wdata[3];
            end
            if (fin_vld && cur_ch == CW'(c)) begin
                busy_clr[c] = 1'b1;
                done_set[c] = 1'b1;
                err_set[c]  = fin_err;
            end
        end
    end

    always_comb begin
        gnt   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(rr_ptr) + i) % NCH;
            if (!found && busy_q[idx]) begin
                gnt   = CW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
            busy_q <= '0; done_q <= '0; err_q <= '0; ien_q <= '0;
            ready_en              <= 1'b0;
            dma_cfg_icb_rsp_valid <= 1'b0;
            dma_cfg_icb_rsp_err   <= 1'b0;
            dma_cfg_icb_rsp_rdata <= '0;
        end else begin
            ready_en <= 1'b1;
            busy_q   <= (busy_q & ~busy_clr) | busy_set;
            done_q   <= (done_q & ~done_clr) | done_set;
            err_q    <= (err_q & ~err_clr) | err_set;
            if (wr_ok && !busy_q[cfg_ch]) begin
                case (cfg_reg)
                    2'd0: src_q[cfg_ch] <= merge(src_q[cfg_ch], dma_cfg_icb_cmd_wdata, dma_cfg_icb_cmd_wmask);
                    2'd1: dst_q[cfg_ch] <= merge(dst_q[cfg_ch], dma_cfg_icb_cmd_wdata, dma_cfg_icb_cmd_wmask);
                    2'd2: len_q[cfg_ch] <= LEN_W'(merge(32'(len_q[cfg_ch]), dma_cfg_icb_cmd_wdata,
                                                        dma_cfg_icb_cmd_wmask));
                    default: ;
                endcase
            end
            if (wr_ok && cfg_reg == 2'd3 && dma_cfg_icb_cmd_wmask[0])
                ien_q[cfg_ch] <= dma_cfg_icb_cmd_wdata[4] & IRQ_IMPL;
            if (cfg_hs) begin
                dma_cfg_icb_rsp_valid <= 1'b1;
                dma_cfg_icb_rsp_err   <= !in_map;
                dma_cfg_icb_rsp_rdata <= (dma_cfg_icb_cmd_read && in_map) ? rd_val : 32'd0;
            end else if (dma_cfg_icb_rsp_ready) begin
                dma_cfg_icb_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= CW'(NCH - 1);
            cur_ch            <= '0;
            cur_src           <= '0;
            cur_dst           <= '0;
            cnt_q             <= '0;
            dma_icb_cmd_valid <= 1'b0;
            dma_icb_cmd_read  <= 1'b0;
            dma_icb_cmd_addr  <= '0;
            dma_icb_cmd_wdata <= '0;
            dma_icb_cmd_wmask <= '0;
            dma_icb_rsp_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|busy_q) state <= ARB;
                ARB: begin
                    cur_ch            <= gnt;
                    rr_ptr            <= gnt;
                    cur_src           <= src_q[gnt];
                    cur_dst           <= dst_q[gnt];
                    cnt_q             <= len_q[gnt];
                    dma_icb_cmd_valid <= 1'b1;
                    dma_icb_cmd_read  <= 1'b1;
                    dma_icb_cmd_addr  <= src_q[gnt];
                    dma_icb_cmd_wdata <= '0;
                    dma_icb_cmd_wmask <= '0;
                    state             <= RD_CMD;
                end
                RD_CMD, WR_CMD: if (dma_icb_cmd_ready) begin
                    dma_icb_cmd_valid <= 1'b0;
                    dma_icb_rsp_ready <= 1'b1;
                    state             <= (state == RD_CMD) ? RD_RSP : WR_RSP;
                end
                RD_RSP: if (dma_icb_rsp_valid) begin
                    dma_icb_rsp_ready <= 1'b0;
                    if (dma_icb_rsp_err) begin
                        state <= IDLE;
                    end else begin
                        dma_icb_cmd_valid <= 1'b1;
                        dma_icb_cmd_read  <= 1'b0;
                        dma_icb_cmd_addr  <= cur_dst;
                        dma_icb_cmd_wdata <= dma_icb_rsp_rdata;
                        dma_icb_cmd_wmask <= 4'hF;
                        state             <= WR_CMD;
                    end
                end
                WR_RSP: if (dma_icb_rsp_valid) begin
                    dma_icb_rsp_ready <= 1'b0;
                    state             <= dma_icb_rsp_err ? IDLE : NEXT;
                end
                NEXT: begin
                    cur_src <= cur_src + 32'd4;
                    cur_dst <= cur_dst + 32'd4;
                    cnt_q   <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        dma_icb_cmd_valid <= 1'b1;
                        dma_icb_cmd_read  <= 1'b1;
                        dma_icb_cmd_addr  <= cur_src + 32'd4;
                        dma_icb_cmd_wdata <= '0;
                        dma_icb_cmd_wmask <= '0;
                        state             <= RD_CMD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dma_irq <= 1'b0;
        else        dma_irq <= |(ien_q & (done_q | err_q));
    end
`else
    assign dma_irq = 1'b0;
`endif
endmodule

// File: tb/tb_dma_mch_engine.sv
// Directed bench for dma_mch_engine: config register access, copy, arbitration, stalls, errors, reset.
module tb_dma_mch_engine;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] PAT  = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_read = 1'b0;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0;
    logic [3:0]  cfg_wmask = '0;
    logic        cfg_ready, cfg_rsp_valid, cfg_rsp_err;
    logic [31:0] cfg_rsp_rdata;
    logic        cfg_rsp_ready = 1'b1;
    logic        m_valid, m_read, m_rsp_ready;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    logic        m_ready = 1'b1, m_rsp_valid = 1'b0, m_rsp_err = 1'b0;
    logic [31:0] m_rsp_rdata = '0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_wdata [$];
    logic        log_rd [$];
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    int          err_idx = 0;

`ifdef DMA_IRQ_EN
    localparam logic [31:0] IEN_BIT = 32'h10;
    localparam logic        IRQ_EXP = 1'b1;
`else
    localparam logic [31:0] IEN_BIT = 32'h00;
    localparam logic        IRQ_EXP = 1'b0;
`endif

    dma_mch_engine dut (
        .clk(clk), .rst_n(rst_n),
        .dma_cfg_icb_cmd_valid(cfg_valid), .dma_cfg_icb_cmd_read(cfg_read),
        .dma_cfg_icb_cmd_addr(cfg_addr), .dma_cfg_icb_cmd_wdata(cfg_wdata),
        .dma_cfg_icb_cmd_wmask(cfg_wmask), .dma_cfg_icb_cmd_ready(cfg_ready),
        .dma_cfg_icb_rsp_valid(cfg_rsp_valid), .dma_cfg_icb_rsp_err(cfg_rsp_err),
        .dma_cfg_icb_rsp_rdata(cfg_rsp_rdata), .dma_cfg_icb_rsp_ready(cfg_rsp_ready),
        .dma_icb_cmd_valid(m_valid), .dma_icb_cmd_read(m_read), .dma_icb_cmd_addr(m_addr),
        .dma_icb_cmd_wdata(m_wdata), .dma_icb_cmd_wmask(m_wmask), .dma_icb_cmd_ready(m_ready),
        .dma_icb_rsp_valid(m_rsp_valid), .dma_icb_rsp_err(m_rsp_err),
        .dma_icb_rsp_rdata(m_rsp_rdata), .dma_icb_rsp_ready(m_rsp_ready),
        .dma_irq(irq)
    );

    always #5 clk = ~clk;

    // Memory-side slave: one-cycle response, read data = addr ^ PAT, optional stall and error.
    initial begin : slave
        logic hs_c, hs_r, v, c_rd;
        logic [31:0] c_addr, c_wd;
        forever begin
            @(negedge clk);
            hs_c   = m_valid && m_ready;
            hs_r   = m_rsp_valid && m_rsp_ready;
            v      = m_valid;
            c_rd   = m_read;
            c_addr = m_addr;
            c_wd   = m_wdata;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_rsp_valid = 1'b0;
                m_rsp_err   = 1'b0;
                m_rsp_rdata = '0;
            end else begin
                if (hs_r) begin
                    m_rsp_valid = 1'b0;
                    m_rsp_err   = 1'b0;
                    m_rsp_rdata = '0;
                end
                if (hs_c) begin
                    log_addr.push_back(c_addr);
                    log_wdata.push_back(c_wd);
                    log_rd.push_back(c_rd);
                    m_rsp_valid = 1'b1;
                    if (c_rd) begin
                        rd_cnt++;
                        m_rsp_rdata = c_addr ^ PAT;
                        m_rsp_err   = (rd_cnt == err_idx);
                    end else begin
                        m_rsp_rdata = '0;
                        m_rsp_err   = 1'b0;
                    end
                end
                if (stall_cnt > 0 && v) stall_cnt--;
            end
            m_ready = (stall_cnt == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input int r);
        return BASE + 32'(16 * ch) + 32'(4 * r);
    endfunction

    task automatic cfg(input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] q, output logic e);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_read = rd; cfg_addr = a; cfg_wdata = d; cfg_wmask = m;
        n = 0;
        while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("cfg_rsp_timeout", 32'(cfg_rsp_valid), 32'd1);
        q = cfg_rsp_rdata;
        e = cfg_rsp_err;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        logic [31:0] q; logic e;
        cfg(1'b0, ra(ch, r), d, 4'hF, q, e);
        chk("wr_err", 32'(e), 32'd0);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] q);
        logic e;
        cfg(1'b1, ra(ch, r), 32'd0, 4'h0, q, e);
    endtask

    task automatic wait_idle(input int ch);
        logic [31:0] q;
        q = 32'h2;
        for (int i = 0; i < 100 && q[1]; i++) rd(ch, 3, q);
        chk("busy_drops", {31'd0, q[1]}, 32'd0);
    endtask

    task automatic log_clear();
        log_addr.delete(); log_wdata.delete(); log_rd.delete();
    endtask

    task automatic chk_copy(input int base, input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int k = 0; k < len; k++) begin
            int i = base + 2 * k;
            chk("rd_addr", (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_DEAD, src + 32'(4 * k));
            chk("rd_kind", (i < log_rd.size()) ? 32'(log_rd[i]) : 32'hDEAD_DEAD, 32'd1);
            chk("wr_addr", (i + 1 < log_addr.size()) ? log_addr[i+1] : 32'hDEAD_DEAD, dst + 32'(4 * k));
            chk("wr_data", (i + 1 < log_wdata.size()) ? log_wdata[i+1] : 32'hDEAD_DEAD,
                (src + 32'(4 * k)) ^ PAT);
        end
    endtask

    initial begin : main
        logic [31:0] q;
        logic e;
        int stall_seen, n;
        logic stable_ok;

        // Reset values
        #2;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_rsp_ready", 32'(m_rsp_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(0, 3, q); chk("rst_ctrl0", q, 32'd0);
        rd(1, 0, q); chk("rst_src1", q, 32'd0);

        // Byte-lane masks on SRC
        wr(1, 0, 32'hAABB_CCDD);
        cfg(1'b0, ra(1, 0), 32'h1122_3344, 4'b0101, q, e);
        rd(1, 0, q); chk("wmask_0101", q, 32'hAA22_CC44);
        cfg(1'b0, ra(1, 0), 32'h0000_0000, 4'b0000, q, e);
        chk("wmask0_err", 32'(e), 32'd0);
        rd(1, 0, q); chk("wmask0_noop", q, 32'hAA22_CC44);

        // Pair started back-to-back after reset: ch0 first, then ch1, no interleave
        wr(0, 0, 32'h3000_0000); wr(0, 1, 32'h3000_1000); wr(0, 2, 32'd2);
        wr(1, 0, 32'h4000_0000); wr(1, 1, 32'h4000_1000); wr(1, 2, 32'd2);
        log_clear();
        wr(0, 3, 32'h1); wr(1, 3, 32'h1);
        wait_idle(0); wait_idle(1);
        chk("pair1_count", 32'(log_addr.size()), 32'd8);
        chk_copy(0, 32'h3000_0000, 32'h3000_1000, 2);
        chk_copy(4, 32'h4000_0000, 32'h4000_1000, 2);
        wr(0, 3, 32'h4); wr(1, 3, 32'h4);

        // Single 3-word copy on ch0, with ignored LEN write while busy
        wr(0, 0, 32'h2000_0000); wr(0, 1, 32'h2000_1000); wr(0, 2, 32'd3);
        log_clear();
        wr(0, 3, 32'h11);
        wr(0, 2, 32'd9);
        wait_idle(0);
        chk("copy3_count", 32'(log_addr.size()), 32'd6);
        chk_copy(0, 32'h2000_0000, 32'h2000_1000, 3);
        rd(0, 3, q); chk("copy3_ctrl", q, 32'h04 | IEN_BIT);
        chk("copy3_irq", 32'(irq), 32'(IRQ_EXP));
        rd(0, 2, q); chk("len_busy_ignored", q, 32'd3);
        rd(0, 0, q); chk("src_unchanged", q, 32'h2000_0000);
        wr(0, 3, 32'h4);
        rd(0, 3, q); chk("done_w1c", q, 32'd0);
        chk("irq_clear", 32'(irq), 32'd0);

        // Second pair: last served was ch0, so ch1 goes first
        wr(0, 0, 32'h3000_0000); wr(0, 1, 32'h3000_1000); wr(0, 2, 32'd2);
        log_clear();
        wr(0, 3, 32'h1); wr(1, 3, 32'h1);
        wait_idle(0); wait_idle(1);
        chk("pair2_count", 32'(log_addr.size()), 32'd8);
        chk_copy(0, 32'h4000_0000, 32'h4000_1000, 2);
        chk_copy(4, 32'h3000_0000, 32'h3000_1000, 2);
        wr(0, 3, 32'h4); wr(1, 3, 32'h4);

        // Master cmd_ready held low for 5 cycles
        wr(1, 0, 32'h5000_0000); wr(1, 1, 32'h5000_1000); wr(1, 2, 32'd1);
        log_clear();
        stall_cnt = 5;
        wr(1, 3, 32'h1);
        stall_seen = 0; stable_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid && !m_ready) begin
                stall_seen++;
                if (m_addr !== 32'h5000_0000 || m_read !== 1'b1) stable_ok = 1'b0;
            end
        end
        chk("stall_cycles", 32'(stall_seen), 32'd5);
        chk("stall_stable", 32'(stable_ok), 32'd1);
        wait_idle(1);
        chk("stall_no_dup", 32'(log_addr.size()), 32'd2);
        chk_copy(0, 32'h5000_0000, 32'h5000_1000, 1);
        wr(1, 3, 32'h4);

        // Error on the 2nd read of a 4-word copy
        wr(0, 0, 32'h6000_0000); wr(0, 1, 32'h6000_1000); wr(0, 2, 32'd4);
        log_clear();
        rd_cnt = 0; err_idx = 2;
        wr(0, 3, 32'h1);
        wait_idle(0);
        repeat (5) @(negedge clk);
        err_idx = 0;
        rd(0, 3, q); chk("err_ctrl", q, 32'h0C);
        chk("err_count", 32'(log_addr.size()), 32'd3);
        chk("err_one_write", (log_rd.size() > 1) ? 32'(log_rd[1]) : 32'hDEAD_DEAD, 32'd0);
        chk("err_rd2_addr", (log_addr.size() > 2) ? log_addr[2] : 32'hDEAD_DEAD, 32'h6000_0004);
        wr(0, 3, 32'hC);
        rd(0, 3, q); chk("err_w1c", q, 32'd0);

        // Out-of-map and misaligned config accesses
        cfg(1'b1, BASE + 32'h40, 32'd0, 4'h0, q, e);
        chk("oob_err", 32'(e), 32'd1);
        chk("oob_rdata", q, 32'd0);
        cfg(1'b1, BASE + 32'h2, 32'd0, 4'h0, q, e);
        chk("misalign_err", 32'(e), 32'd1);
        cfg(1'b0, BASE + 32'h1, 32'hFFFF_FFFF, 4'hF, q, e);
        chk("misalign_wr_err", 32'(e), 32'd1);
        rd(0, 0, q); chk("misalign_no_change", q, 32'h6000_0000);

        // LEN=0 start: DONE at once, no master traffic
        wr(1, 2, 32'd0);
        log_clear();
        wr(1, 3, 32'h1);
        rd(1, 3, q); chk("len0_done", q, 32'h04);
        repeat (10) @(negedge clk);
        chk("len0_no_traffic", 32'(log_addr.size()), 32'd0);
        wr(1, 3, 32'h4);

        // Reset pulsed while a write command is pending
        wr(0, 0, 32'h7000_0000); wr(0, 1, 32'h7000_1000); wr(0, 2, 32'd2);
        wr(0, 3, 32'h1);
        n = 0;
        while (!(m_valid && !m_read) && n < 60) begin @(negedge clk); n++; end
        chk("wr_cmd_reached", 32'(n < 60), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_addr", m_addr, 32'd0);
        chk("mid_rst_m_wdata", m_wdata, 32'd0);
        chk("mid_rst_m_wmask", 32'(m_wmask), 32'd0);
        chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(0, 3, q); chk("post_rst_ctrl", q, 32'd0);
        rd(0, 0, q); chk("post_rst_src", q, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
